iomem_bellek_yanitlayici: RTL and testbench
===========================================

Name: iomem_bellek_yanitlayici

Overview:
Slave-side responder for the core's iomem valid/ready port. It accepts one request at a time, waits a programmable number of cycles, then performs a byte-strobed write or a word read on an internal word-addressed RAM. It returns `iomem_ready` for one cycle with read data. It replaces ad-hoc bench glue (combinational memory model plus delay shift register) with a synthesizable, latency-accurate memory stage directly downstream of the processor.

Parameters:
- BASE_ADDR, 32'h4000_0000, byte address of word 0.
- MEM_DEPTH, 32'h0000_1000, number of 32-bit words; must be a power of two.
- LATENCY, 1, edges from request acceptance to ready assertion; legal range 1..15.
- ERR_DATA, 32'h0000_0000, value driven on `iomem_rdata_o` for out-of-range reads.

Ports:
- `clk_i`  in  1  clock
- `rst_i`  in  1  asynchronous reset, active-high
- `iomem_valid_i`  in  1  request valid; held by master until ready
- `iomem_ready_o`  out  1  one-cycle completion pulse
- `iomem_wstrb_i`  in  4  byte write strobes; 0 = read
- `iomem_addr_i`  in  32  byte address
- `iomem_wdata_i`  in  32  write data
- `iomem_rdata_o`  out  32  read data, valid while ready is high
- `err_o`  out  1  pulses with ready when the address was out of range
- `rd_cnt_o`  out  32  completed in-range reads
- `wr_cnt_o`  out  32  completed in-range writes

Behaviour:
- Reset (async, rst_i=1):
  - state=IDLE.
  - `iomem_ready_o`=0, `err_o`=0, `iomem_rdata_o`=0, both counters=0.
  - RAM contents are not cleared. The RAM array is plain reg storage so the bench can preload it hierarchically with $readmemh.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - On an edge with `iomem_valid_i`=1, latch addr, wdata, wstrb.
  - Load cnt=LATENCY-1.
  - Next state is RESP if LATENCY==1, else WAIT.
- WAIT:
  - cnt decrements each edge.
  - Go to RESP on the edge where cnt==1.
  - `iomem_valid_i` is ignored in this state; the request was already latched.
- Entry into RESP (the edge that sets ready):
  - In-range write: each lane i with wstrb[i]=1 writes wdata[8i+7:8i] into mem[word]. Lanes with wstrb[i]=0 are unchanged. `iomem_rdata_o`=0. wr_cnt+1.
  - In-range read: `iomem_rdata_o`=mem[word]. rd_cnt+1.
  - Out of range: no RAM write, no counter change. `iomem_rdata_o`=ERR_DATA, `err_o`=1.
- RESP:
  - `iomem_ready_o`=1 for exactly this one cycle.
  - Always returns to IDLE on the next edge.
- Back-to-back: IDLE resamples valid on the first edge after RESP, so valid held continuously yields one transaction per LATENCY+1 cycles. With LATENCY=1, ready appears in the cycle after valid is first sampled, then every 2 cycles.
- Address decoding:
  - word = (addr - BASE_ADDR) >> 2.
  - In range iff BASE_ADDR <= addr < BASE_ADDR + 4*MEM_DEPTH, using 32-bit unsigned compare.
  - addr[1:0] is ignored (word-aligned access).
- `iomem_rdata_o` holds its value outside RESP until the next access. `err_o` is 0 outside RESP.
- Counters wrap 32'hFFFF_FFFF -> 0 silently.
- Reset mid-transaction: ready and err drop asynchronously and state goes to IDLE. A write whose RESP-entry edge has not yet occurred is never committed.

Test Plan:
1. Write then read, LATENCY=1:
   - valid, addr=4000_0010, wstrb=F, wdata=DEADBEEF -> ready high exactly 1 cycle after first sample, wr_cnt=1.
   - Read same addr -> rdata=DEADBEEF, rd_cnt=1.
2. Byte strobes:
   - Preload word 4 = 11223344; write wstrb=0101, wdata=AABBCCDD.
   - Read -> 11BB33DD.
3. Latency sweep, LATENCY=4:
   - Ready asserts on the 4th edge after acceptance.
   - Valid held through WAIT causes no second access; 3 reads take 15 cycles.
4. Out of range:
   - addr=3FFF_FFFC read -> ready with err_o=1, rdata=ERR_DATA, rd_cnt unchanged.
   - addr=4000_4000 write -> err_o=1, RAM unchanged.
5. Reset mid-op, LATENCY=3:
   - Assert rst_i during WAIT of a write to 4000_0000 -> ready=0 immediately, readback after reset shows old word.
6. $readmemh preload of the rv32um mul image -> processor running the test reads the correct first instruction at BASE_ADDR.

Source files
------------

// File: rtl/iomem_bellek_yanitlayici.sv
// Word-addressed RAM responder for the iomem valid/ready port; ready pulses LATENCY edges after acceptance.
// One request in flight; valid is only resampled in IDLE, so a held valid yields one access per LATENCY+1 cycles.
module iomem_bellek_yanitlayici #(
   parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
   parameter logic [31:0] MEM_DEPTH = 32'h0000_1000,
   parameter int unsigned LATENCY   = 1,
   parameter logic [31:0] ERR_DATA  = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        iomem_valid_i,
   output logic        iomem_ready_o,
   input  logic [3:0]  iomem_wstrb_i,
   input  logic [31:0] iomem_addr_i,
   input  logic [31:0] iomem_wdata_i,
   output logic [31:0] iomem_rdata_o,
   output logic        err_o,
   output logic [31:0] rd_cnt_o,
   output logic [31:0] wr_cnt_o
);

   localparam int AW = $clog2(MEM_DEPTH);

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

   state_t      r_state;
   logic [3:0]  r_cnt;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [3:0]  r_wstrb;
   logic        r_ready;
   logic        r_err;
   logic [31:0] r_rdata;
   logic [31:0] r_rd_cnt;
   logic [31:0] r_wr_cnt;
   logic [31:0] r_mem [0:MEM_DEPTH-1];

   logic          w_accept;
   logic          w_enter_resp;
   logic          w_in_range;
   logic [31:0]   w_addr;
   logic [31:0]   w_wdata;
   logic [3:0]    w_wstrb;
   logic [31:0]   w_off;
   logic [AW-1:0] w_idx;

   // With LATENCY==1 the accepting edge is also the RESP-entry edge, so the live bus is used.
   assign w_accept     = (r_state == ST_IDLE) && iomem_valid_i;
   assign w_enter_resp = (w_accept && (LATENCY == 1)) || ((r_state == ST_WAIT) && (r_cnt == 4'd1));
   assign w_addr       = (r_state == ST_IDLE) ? iomem_addr_i  : r_addr;
   assign w_wdata      = (r_state == ST_IDLE) ? iomem_wdata_i : r_wdata;
   assign w_wstrb      = (r_state == ST_IDLE) ? iomem_wstrb_i : r_wstrb;
   assign w_off        = w_addr - BASE_ADDR;
   assign w_in_range   = (w_addr >= BASE_ADDR) && ({2'b00, w_off} < {MEM_DEPTH, 2'b00});
   assign w_idx        = w_off[AW+1:2];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state  <= ST_IDLE;
         r_cnt    <= '0;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_wstrb  <= '0;
         r_ready  <= 1'b0;
         r_err    <= 1'b0;
         r_rdata  <= '0;
         r_rd_cnt <= '0;
         r_wr_cnt <= '0;
      end else begin
         r_ready <= 1'b0;
         r_err   <= 1'b0;
         if (w_enter_resp) begin
            r_ready <= 1'b1;
            if (!w_in_range) begin
               r_rdata <= ERR_DATA;
               r_err   <= 1'b1;
            end else if (w_wstrb != 4'd0) begin
               r_rdata  <= '0;
               r_wr_cnt <= r_wr_cnt + 32'd1;
            end else begin
               r_rdata  <= r_mem[w_idx];
               r_rd_cnt <= r_rd_cnt + 32'd1;
            end
         end
         case (r_state)
            ST_IDLE: begin
               if (iomem_valid_i) begin
                  r_addr  <= iomem_addr_i;
                  r_wdata <= iomem_wdata_i;
                  r_wstrb <= iomem_wstrb_i;
                  r_cnt   <= 4'(LATENCY - 1);
                  r_state <= (LATENCY == 1) ? ST_RESP : ST_WAIT;
               end
            end
            ST_WAIT: begin
               r_cnt <= r_cnt - 4'd1;
               if (r_cnt == 4'd1) r_state <= ST_RESP;
            end
            ST_RESP: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // No reset on the array so it maps to RAM; gating on rst_i keeps an aborted write from landing.
   always_ff @(posedge clk_i) begin
      if (!rst_i && w_enter_resp && w_in_range) begin
         for (int i = 0; i < 4; i++) begin
            if (w_wstrb[i]) r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
         end
      end
   end

   assign iomem_ready_o = r_ready;
   assign err_o         = r_err;
   assign iomem_rdata_o = r_rdata;
   assign rd_cnt_o      = r_rd_cnt;
   assign wr_cnt_o      = r_wr_cnt;

endmodule

// File: tb/tb_iomem_bellek_yanitlayici.sv
// Bench for iomem_bellek_yanitlayici: three instances (LATENCY 1, 4, 3) driven by directed requests.
// Expected responses, including the cycle ready must appear in, are queued and checked by a monitor.
module tb_iomem_bellek_yanitlayici;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
      logic [31:0] rd;
      logic [31:0] wr;
      logic [31:0] cyc;
   } exp_t;

   logic        clk;
   logic        rst   [3];
   logic        valid [3];
   logic        ready [3];
   logic [3:0]  wstrb [3];
   logic [31:0] addr  [3];
   logic [31:0] wdata [3];
   logic [31:0] rdata [3];
   logic        err   [3];
   logic [31:0] rdc   [3];
   logic [31:0] wrc   [3];

   logic [31:0] cyc;
   logic [31:0] exp_last [3];
   exp_t q0 [$];
   exp_t q1 [$];
   exp_t q2 [$];
   int vectors;
   int miscompares;

   iomem_bellek_yanitlayici #(.LATENCY(1), .ERR_DATA(32'hBADD_BADD)) u_dut0 (
      .clk_i(clk), .rst_i(rst[0]), .iomem_valid_i(valid[0]), .iomem_ready_o(ready[0]),
      .iomem_wstrb_i(wstrb[0]), .iomem_addr_i(addr[0]), .iomem_wdata_i(wdata[0]),
      .iomem_rdata_o(rdata[0]), .err_o(err[0]), .rd_cnt_o(rdc[0]), .wr_cnt_o(wrc[0]));

   iomem_bellek_yanitlayici #(.LATENCY(4)) u_dut1 (
      .clk_i(clk), .rst_i(rst[1]), .iomem_valid_i(valid[1]), .iomem_ready_o(ready[1]),
      .iomem_wstrb_i(wstrb[1]), .iomem_addr_i(addr[1]), .iomem_wdata_i(wdata[1]),
      .iomem_rdata_o(rdata[1]), .err_o(err[1]), .rd_cnt_o(rdc[1]), .wr_cnt_o(wrc[1]));

   iomem_bellek_yanitlayici #(.LATENCY(3)) u_dut2 (
      .clk_i(clk), .rst_i(rst[2]), .iomem_valid_i(valid[2]), .iomem_ready_o(ready[2]),
      .iomem_wstrb_i(wstrb[2]), .iomem_addr_i(addr[2]), .iomem_wdata_i(wdata[2]),
      .iomem_rdata_o(rdata[2]), .err_o(err[2]), .rd_cnt_o(rdc[2]), .wr_cnt_o(wrc[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = '0;
   always @(posedge clk) cyc <= cyc + 32'd1;

   function automatic logic [31:0] lat_of(input int d);
      return (d == 0) ? 32'd1 : (d == 1) ? 32'd4 : 32'd3;
   endfunction

   function automatic int qsize(input int d);
      return (d == 0) ? q0.size() : (d == 1) ? q1.size() : q2.size();
   endfunction

   task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] expv);
      vectors++;
      if (act !== expv) begin
         miscompares++;
         $display("FAIL %s dut%0d @cyc %0d: got %h, expected %h", name, d, cyc, act, expv);
      end
   endtask

   task automatic push(input int d, input exp_t e);
      case (d)
         0: q0.push_back(e);
         1: q1.push_back(e);
         default: q2.push_back(e);
      endcase
   endtask

   always @(negedge clk) begin
      for (int d = 0; d < 3; d++) begin
         if (ready[d] === 1'b1) begin
            if (qsize(d) == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL spurious_ready dut%0d @cyc %0d: got ready=1, expected no response", d, cyc);
            end else begin
               exp_t e;
               case (d)
                  0: e = q0.pop_front();
                  1: e = q1.pop_front();
                  default: e = q2.pop_front();
               endcase
               chk("ready_cycle", d, cyc, e.cyc);
               chk("rdata", d, rdata[d], e.rdata);
               chk("err", d, {31'd0, err[d]}, {31'd0, e.err});
               chk("rd_cnt", d, rdc[d], e.rd);
               chk("wr_cnt", d, wrc[d], e.wr);
            end
         end else begin
            chk("err_idle", d, {31'd0, err[d]}, 32'd0);
         end
      end
   end

   // Issue one request at the current negedge and wait for its ready; hold keeps valid asserted afterwards.
   task automatic req(input int d, input logic [31:0] a, input logic [3:0] s, input logic [31:0] w,
                      input logic [31:0] er, input logic ee, input logic [31:0] erd,
                      input logic [31:0] ewr, input bit hold);
      exp_t e;
      int   n;
      e.rdata = er;
      e.err   = ee;
      e.rd    = erd;
      e.wr    = ewr;
      e.cyc   = cyc + lat_of(d) + ((cyc == exp_last[d]) ? 32'd1 : 32'd0);
      exp_last[d] = e.cyc;
      push(d, e);
      valid[d] = 1'b1;
      addr[d]  = a;
      wstrb[d] = s;
      wdata[d] = w;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (ready[d] !== 1'b1 && n < 60);
      if (ready[d] !== 1'b1) begin
         vectors++;
         miscompares++;
         $display("FAIL timeout dut%0d addr %h: got no ready in 60 cycles, expected ready", d, a);
      end
      if (!hold) valid[d] = 1'b0;
   endtask

   initial begin
      logic [31:0] t0;
      vectors     = 0;
      miscompares = 0;
      for (int d = 0; d < 3; d++) begin
         rst[d]      = 1'b1;
         valid[d]    = 1'b0;
         wstrb[d]    = '0;
         addr[d]     = '0;
         wdata[d]    = '0;
         exp_last[d] = 32'hFFFF_FFFF;
      end
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         chk("rst_ready", d, {31'd0, ready[d]}, 32'd0);
         chk("rst_rdata", d, rdata[d], 32'd0);
         chk("rst_rd_cnt", d, rdc[d], 32'd0);
         chk("rst_wr_cnt", d, wrc[d], 32'd0);
      end
      @(negedge clk);
      for (int d = 0; d < 3; d++) rst[d] = 1'b0;
      @(negedge clk);

      // LATENCY=1: write/read, byte strobes, range boundaries, address low bits
      req(0, 32'h4000_0000, 4'hF, 32'h0102_0304, 32'h0000_0000, 1'b0, 32'd0, 32'd1, 1'b0);
      req(0, 32'h4000_0010, 4'hF, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 32'd0, 32'd2, 1'b0);
      req(0, 32'h4000_0010, 4'h0, 32'h0,         32'hDEAD_BEEF, 1'b0, 32'd1, 32'd2, 1'b0);
      req(0, 32'h4000_0010, 4'hF, 32'h1122_3344, 32'h0000_0000, 1'b0, 32'd1, 32'd3, 1'b0);
      req(0, 32'h4000_0010, 4'h5, 32'hAABB_CCDD, 32'h0000_0000, 1'b0, 32'd1, 32'd4, 1'b0);
      req(0, 32'h4000_0013, 4'h0, 32'h0,         32'h11BB_33DD, 1'b0, 32'd2, 32'd4, 1'b0);
      req(0, 32'h3FFF_FFFC, 4'h0, 32'h0,         32'hBADD_BADD, 1'b1, 32'd2, 32'd4, 1'b0);
      req(0, 32'h4000_4000, 4'hF, 32'h5555_5555, 32'hBADD_BADD, 1'b1, 32'd2, 32'd4, 1'b0);
      req(0, 32'h4000_0000, 4'h0, 32'h0,         32'h0102_0304, 1'b0, 32'd3, 32'd4, 1'b0);
      req(0, 32'h4000_3FFF, 4'hF, 32'h7777_8888, 32'h0000_0000, 1'b0, 32'd3, 32'd5, 1'b0);
      req(0, 32'h4000_3FFC, 4'h0, 32'h0,         32'h7777_8888, 1'b0, 32'd4, 32'd5, 1'b0);
      req(0, 32'h4000_0000, 4'h0, 32'h0,         32'h0102_0304, 1'b0, 32'd5, 32'd5, 1'b1);
      req(0, 32'h4000_3FFC, 4'h0, 32'h0,         32'h7777_8888, 1'b0, 32'd6, 32'd5, 1'b1);
      req(0, 32'h4000_0010, 4'h0, 32'h0,         32'h11BB_33DD, 1'b0, 32'd7, 32'd5, 1'b0);

      // LATENCY=4: valid held across three reads
      req(1, 32'h4000_0020, 4'hF, 32'h0000_AAAA, 32'h0000_0000, 1'b0, 32'd0, 32'd1, 1'b0);
      req(1, 32'h4000_0024, 4'hF, 32'h0000_BBBB, 32'h0000_0000, 1'b0, 32'd0, 32'd2, 1'b0);
      @(negedge clk);
      t0 = cyc;
      req(1, 32'h4000_0020, 4'h0, 32'h0, 32'h0000_AAAA, 1'b0, 32'd1, 32'd2, 1'b1);
      req(1, 32'h4000_0024, 4'h0, 32'h0, 32'h0000_BBBB, 1'b0, 32'd2, 32'd2, 1'b1);
      req(1, 32'h4000_0020, 4'h0, 32'h0, 32'h0000_AAAA, 1'b0, 32'd3, 32'd2, 1'b0);
      chk("b2b_cycles", 1, cyc - t0 + 32'd1, 32'd15);

      // LATENCY=3: reset during WAIT of a write, then reset during RESP
      req(2, 32'h4000_0000, 4'hF, 32'h1234_5678, 32'h0000_0000, 1'b0, 32'd0, 32'd1, 1'b0);
      @(negedge clk);
      valid[2] = 1'b1;
      addr[2]  = 32'h4000_0000;
      wstrb[2] = 4'hF;
      wdata[2] = 32'hCAFE_F00D;
      @(negedge clk);
      @(negedge clk);
      #1;
      rst[2]   = 1'b1;
      valid[2] = 1'b0;
      #1;
      chk("midop_ready", 2, {31'd0, ready[2]}, 32'd0);
      chk("midop_wr_cnt", 2, wrc[2], 32'd0);
      @(negedge clk);
      rst[2] = 1'b0;
      @(negedge clk);
      req(2, 32'h4000_0000, 4'h0, 32'h0, 32'h1234_5678, 1'b0, 32'd1, 32'd0, 1'b0);
      #1;
      rst[2] = 1'b1;
      #1;
      chk("async_ready", 2, {31'd0, ready[2]}, 32'd0);
      chk("async_rd_cnt", 2, rdc[2], 32'd0);
      chk("async_rdata", 2, rdata[2], 32'd0);
      @(negedge clk);
      rst[2] = 1'b0;

      repeat (4) @(negedge clk);
      for (int d = 0; d < 3; d++) chk("queue_empty", d, qsize(d), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
